// File: rtl/timer_irq_controller.sv
// Interrupt controller for the interval timer irq plus peripheral lines.
// Each source is synchronised, latched as level or rising-edge, masked, and
// merged into one registered irq; ACTIVE_ID names the lowest pending source.
module timer_irq_controller #(
    parameter int unsigned NUM_SRC     = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic               irq
);

    localparam logic [2:0] AddrPending = 3'd0;
    localparam logic [2:0] AddrMask    = 3'd1;
    localparam logic [2:0] AddrEdge    = 3'd2;
    localparam logic [2:0] AddrActive  = 3'd3;
    localparam logic [2:0] AddrRaw     = 3'd4;
    localparam logic [2:0] AddrForce   = 3'd5;
    localparam logic [2:0] AddrOverrun = 3'd6;

    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
    logic [NUM_SRC-1:0] sync;
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] edge_q, edge_d;
    logic [NUM_SRC-1:0] overrun_q, overrun_d;
    logic [NUM_SRC-1:0] wdata, rise, set_bits, clr_pend, clr_ovr, force_bits, enabled;
    logic               wr_en;
    logic [3:0]         active_id;
    logic               active_valid;
    logic [15:0]        rd_mux;

    // Writedata bits above NUM_SRC are intentionally ignored.
    if (NUM_SRC < 16) begin : g_unused_wdata
        logic unused_wdata_hi;
        assign unused_wdata_hi = ^writedata[15:NUM_SRC];
    end

    function automatic logic [15:0] zext(logic [NUM_SRC-1:0] v);
        logic [15:0] r;
        r = '0;
        r[NUM_SRC-1:0] = v;
        return r;
    endfunction

    assign sync  = sync_q[SYNC_STAGES-1];
    assign wr_en = chipselect & ~write_n;
    assign wdata = writedata[NUM_SRC-1:0];

    // Input synchroniser chain and edge history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
            prev_q <= sync;
        end
    end

    // Decode register writes and compute latch/overrun next state.
    always_comb begin
        clr_pend   = (wr_en && address == AddrPending) ? wdata : '0;
        clr_ovr    = (wr_en && address == AddrOverrun) ? wdata : '0;
        force_bits = (wr_en && address == AddrForce) ? wdata : '0;
        mask_d     = (wr_en && address == AddrMask) ? wdata : mask_q;
        edge_d     = (wr_en && address == AddrEdge) ? wdata : edge_q;
        rise       = sync & ~prev_q;
        // Set terms win over a simultaneous write-1-to-clear.
        set_bits   = (edge_q & rise) | (~edge_q & sync) | force_bits;
        pending_d  = set_bits | (pending_q & ~clr_pend);
        overrun_d  = (edge_q & rise & pending_q & ~clr_pend) | (overrun_q & ~clr_ovr);
    end

    // Lowest-numbered enabled pending source.
    always_comb begin
        enabled      = pending_q & mask_q;
        active_valid = |enabled;
        active_id    = 4'd0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (enabled[i]) begin
                active_id = 4'(i);
            end
        end
    end

    // Register read multiplexer.
    always_comb begin
        rd_mux = '0;
        case (address)
            AddrPending: rd_mux = zext(pending_q);
            AddrMask:    rd_mux = zext(mask_q);
            AddrEdge:    rd_mux = zext(edge_q);
            AddrActive:  rd_mux = {active_valid, 11'd0, active_id};
            AddrRaw:     rd_mux = zext(sync);
            AddrOverrun: rd_mux = zext(overrun_q);
            default:     rd_mux = '0;
        endcase
    end

    // Control/status registers, registered read data and combined irq.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            mask_q    <= '0;
            edge_q    <= '0;
            overrun_q <= '0;
            readdata  <= '0;
            irq       <= 1'b0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            edge_q    <= edge_d;
            overrun_q <= overrun_d;
            readdata  <= rd_mux;
            irq       <= active_valid;
        end
    end

endmodule

// File: doc/timer_irq_controller.md
Name: timer_irq_controller

Overview:
- Avalon-MM interrupt controller that consumes the interval timer's irq and up to 15 other peripheral interrupt lines.
- Synchronises each source and latches it as level- or edge-triggered, with per-source mask, software force and overrun flags.
- Merges everything into one registered irq to the CPU, and reports the lowest-numbered active source so the ISR can dispatch without scanning.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..16); source 0 is the interval timer irq.
- SYNC_STAGES, 2, flip-flops in each input synchroniser (2..3).

Ports:
- clk  input  1  system clock, one clock domain for all logic.
- reset  input  1  asynchronous, active-high reset.
- address  input  3  register word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  16  write data; bits at or above NUM_SRC are ignored.
- readdata  output  16  registered read data.
- irq_in  input  NUM_SRC  raw interrupt sources, active-high, may be asynchronous.
- irq  output  1  combined interrupt to the CPU, registered.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high.
- Reset values: all registers, synchroniser flops, edge-history flops, readdata and irq are 0.
- Write: occurs when chipselect && !write_n. Read data is captured every cycle from the address mux (readdata <= mux), giving 1-cycle read latency. No wait states.
- Register map (NUM_SRC-bit fields, zero-extended to 16 bits):
  - 0 PENDING: read; write-1-to-clear.
  - 1 MASK: read/write; 1 = source enabled.
  - 2 EDGE: read/write; 1 = rising-edge mode, 0 = level mode.
  - 3 ACTIVE_ID: read-only. bit15 = valid (|(PENDING & MASK)), bits3:0 = index of the lowest-numbered set bit of PENDING & MASK, and 0 when not valid. Writes are ignored.
  - 4 RAW: read-only; synchronised irq_in.
  - 5 FORCE: write-only; each 1 bit sets the corresponding PENDING bit. Reads return 0.
  - 6 OVERRUN: read; write-1-to-clear.
  - 7: reads 0, writes ignored.
- Synchroniser: sync[i] is irq_in[i] delayed through SYNC_STAGES flops.
- Edge detection: prev[i] <= sync[i] every cycle, regardless of mode. rise[i] = sync[i] & ~prev[i]. Changing EDGE mid-operation therefore causes no spurious edge.
- Set term per source: set[i] = (EDGE[i] ? rise[i] : sync[i]) | force_write_bit[i].
- Pending update per clock: PENDING[i] <= set[i] | (PENDING[i] & ~clr[i]), where clr is the write-1-to-clear data on address 0.
  - Set wins over a simultaneous clear.
  - A level source that is still high re-asserts its bit in the cycle after the clear write.
- Overrun: OVERRUN[i] is set when rise[i] occurs in edge mode, PENDING[i] is already 1, and it is not being cleared that cycle. Set wins over a simultaneous clear.
- MASK does not gate PENDING; masked sources still latch and become visible once unmasked.
- irq <= |(PENDING & MASK), registered. irq therefore follows the PENDING register by one clock.
- Latency from an irq_in rising edge: SYNC_STAGES clocks to sync, +1 to PENDING, +1 to irq. Default total is 4 clocks.
- Edge mode at reset release: a source already high after reset produces one rise event, because the sync and prev flops reset to 0.
- Reset mid-operation clears all state immediately and asynchronously; irq drops without waiting for a clock.
- Pulse width: edge sources must be high for ≥ 1 clk period to be captured. Pulses shorter than that may be lost, and this is acceptable.

Test Plan:
- Reset, then read addresses 0–7 → all return 0x0000; irq = 0.
- Write MASK = 0x0001, EDGE = 0; hold irq_in[0] high → irq = 1 exactly 4 clocks after irq_in rises. ACTIVE_ID = 0x8000. Write 0x0001 to PENDING while the source is still high → PENDING reads 0x0001 again and irq stays high. Drop the source, then clear → irq = 0 two clocks after the clear write.
- EDGE = 0x0004, MASK = 0x0004; pulse irq_in[2] for 1 clock twice without clearing → PENDING = 0x0004 and OVERRUN = 0x0004. Write 0x0004 to each → both read 0.
- MASK = 0x0000; write FORCE = 0x0030 → PENDING = 0x0030, irq = 0, ACTIVE_ID = 0x0000. Then write MASK = 0x0020 → ACTIVE_ID = 0x8005 and irq = 1 on the following clock.
- EDGE = 0x0002; clear-PENDING write of 0x0002 in the same cycle that rise[1] occurs → PENDING bit 1 = 1.
- With irq = 1, assert reset asynchronously mid-cycle → irq, readdata and all registers are 0 before the next clk edge.
